clock_ratio_monitor: RTL and testbench

Receive-side companion to the clock divider: samples a divided clock (toggle-type output of the divider) in the fast `clk` domain and measures its half-period in `clk` cycles. From that measurement it recovers the divider setting that produced it. It declares lock after repeated identical measurements and flags out-of-range or missing input. It sits beside the divider / up-down counter path as a self-check and status source.

---
 rtl/clock_ratio_monitor.sv | 163 ++++++++++++++++
 tb/tb_clock_ratio_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_ratio_monitor.sv
// Recovers the divider setting from a toggling divided clock; optional CLKMON_GLITCH_FILTER_EN adds a 2-cycle level filter.
// Latency: edge_pulse 2 clk after input capture (+2 with filter); locked/ratio registered one cycle after the locking edge.
// Backpressure: none; free-running monitor, range_err/timeout/edge_pulse are single-cycle pulses.
module clock_ratio_monitor #(
    parameter int DIV_W    = 3,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_clk_in,
    output logic [DIV_W-1:0] ratio,
    output logic             locked,
    output logic             edge_pulse,
    output logic             range_err,
    output logic             timeout
);
    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] HP_SAT   = '1;
    localparam logic [CNT_W-1:0] M_MAX    = CNT_W'((1 << DIV_W) - 1);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  LOCK_VAL = MC_W'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hp_cnt, hp_nxt;
    logic [CNT_W-1:0] last_m, last_m_nxt;
    logic [MC_W-1:0]  match_cnt, match_nxt;
    logic [DIV_W-1:0] ratio_nxt;
    logic             locked_nxt;
    logic             s1, s2, s3;

`ifdef CLKMON_GLITCH_FILTER_EN
    logic s2_d, s_filt;

    // A level reaches the history flop only once s2 has held it for two cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s2_d   <= 1'b0;
            s_filt <= 1'b0;
            s3     <= 1'b0;
        end else begin
            s1   <= div_clk_in;
            s2   <= s1;
            s2_d <= s2;
            if (s2 == s2_d)
                s_filt <= s2;
            s3 <= s_filt;
        end
    end

    assign edge_pulse = s_filt ^ s3;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= div_clk_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_pulse = s2 ^ s3;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hp_cnt    <= '0;
            last_m    <= '0;
            match_cnt <= '0;
            ratio     <= '0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            hp_cnt    <= hp_nxt;
            last_m    <= last_m_nxt;
            match_cnt <= match_nxt;
            ratio     <= ratio_nxt;
            locked    <= locked_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        hp_nxt     = (hp_cnt == HP_SAT) ? hp_cnt : hp_cnt + 1'b1;
        last_m_nxt = last_m;
        match_nxt  = match_cnt;
        ratio_nxt  = ratio;
        locked_nxt = locked;
        range_err  = 1'b0;
        timeout    = 1'b0;

        if (!en) begin
            state_nxt  = IDLE;
            hp_nxt     = '0;
            last_m_nxt = '0;
            match_nxt  = '0;
            ratio_nxt  = '0;
            locked_nxt = 1'b0;
        end else begin
            // hp_cnt at an edge is the measurement; the counter restarts from it
            if (edge_pulse)
                hp_nxt = '0;
            case (state)
                IDLE: begin
                    state_nxt = ACQUIRE;
                    hp_nxt    = '0;
                end
                ACQUIRE: begin
                    if (edge_pulse) begin
                        state_nxt = MEASURE;
                        match_nxt = '0;
                    end else if (hp_cnt == TO_VAL) begin
                        timeout = 1'b1;
                        hp_nxt  = '0;
                    end
                end
                MEASURE, LOCKED: begin
                    if (edge_pulse) begin
                        if (state == MEASURE || hp_cnt != CNT_W'(ratio)) begin
                            state_nxt  = MEASURE;
                            locked_nxt = 1'b0;
                            ratio_nxt  = '0;
                            if (hp_cnt > M_MAX) begin
                                range_err = 1'b1;
                                match_nxt = '0;
                            end else begin
                                if (state == MEASURE && match_cnt != '0 && hp_cnt == last_m) begin
                                    match_nxt = match_cnt + 1'b1;
                                end else begin
                                    last_m_nxt = hp_cnt;
                                    match_nxt  = MC_W'(1);
                                end
                                if (match_nxt == LOCK_VAL) begin
                                    state_nxt  = LOCKED;
                                    ratio_nxt  = hp_cnt[DIV_W-1:0];
                                    locked_nxt = 1'b1;
                                end
                            end
                        end
                    end else if (hp_cnt == TO_VAL) begin
                        timeout    = 1'b1;
                        state_nxt  = ACQUIRE;
                        hp_nxt     = '0;
                        match_nxt  = '0;
                        ratio_nxt  = '0;
                        locked_nxt = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Drives a toggling divider model into the monitor and checks every output each cycle
// against a measurement/streak reference model.
module tb_clock_ratio_monitor;
    localparam int DIV_W    = 3;
    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 200;
    localparam int M_MAX    = (1 << DIV_W) - 1;
    localparam int HP_SAT   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             div_clk_in = 1'b0;
    logic [DIV_W-1:0] ratio;
    logic             locked, edge_pulse, range_err, timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_ratio_monitor #(
        .DIV_W(DIV_W), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div_clk_in(div_clk_in),
        .ratio(ratio), .locked(locked), .edge_pulse(edge_pulse),
        .range_err(range_err), .timeout(timeout)
    );

    // Reference model: mode, time of last counter restart, list of accepted measurements
    typedef enum int {M_IDLE, M_ACQ, M_MEAS, M_LOCK} mode_t;
    mode_t mode = M_IDLE;
    int    cyc = 0;
    int    restart = 0;
    int    samples[$];
    int    r_ratio = 0;
    bit    r_locked = 1'b0;
    bit    dly[3] = '{1'b0, 1'b0, 1'b0};
    bit    mvalid = 1'b0;

    // Divider model: output toggles every div_d+1 cycles while toggling=1
    int div_d = 1;
    int div_cnt = 0;
    bit din_lvl = 1'b0;
    bit toggling = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int streak();
        int n = 0;
        for (int i = samples.size() - 1; i >= 0; i--) begin
            if (samples[i] != samples[samples.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic tick(input bit en_v, input bit rst_v);
        int hp;
        bit e, er, to;
        if (toggling) begin
            if (div_cnt >= div_d) begin
                din_lvl = ~din_lvl;
                div_cnt = 0;
            end else begin
                div_cnt++;
            end
        end
        en = en_v;
        rst_n = rst_v;
        div_clk_in = din_lvl;
        #1;
        e  = dly[1] ^ dly[2];
        hp = cyc - restart;
        if (hp > HP_SAT) hp = HP_SAT;
        er = 1'b0;
        to = 1'b0;
        if (mvalid) begin
            check("edge_pulse", 32'(edge_pulse), 32'(e));
            check("locked", 32'(locked), 32'(r_locked));
            check("ratio", 32'(ratio), 32'(r_ratio));
        end
        if (!en_v) begin
            mode = M_IDLE;
            samples.delete();
            r_locked = 1'b0;
            r_ratio = 0;
            restart = cyc + 1;
        end else begin
            if (e) restart = cyc + 1;
            case (mode)
                M_IDLE: begin
                    mode = M_ACQ;
                    restart = cyc + 1;
                end
                M_ACQ: begin
                    if (e) begin
                        mode = M_MEAS;
                        samples.delete();
                    end else if (hp == TIMEOUT) begin
                        to = 1'b1;
                        restart = cyc + 1;
                    end
                end
                default: begin
                    if (e) begin
                        if (!(mode == M_LOCK && hp == r_ratio)) begin
                            if (mode == M_LOCK) samples.delete();
                            mode = M_MEAS;
                            r_locked = 1'b0;
                            r_ratio = 0;
                            if (hp > M_MAX) begin
                                er = 1'b1;
                                samples.delete();
                            end else begin
                                samples.push_back(hp);
                                if (streak() >= LOCK_CNT) begin
                                    mode = M_LOCK;
                                    r_locked = 1'b1;
                                    r_ratio = hp;
                                end
                            end
                        end
                    end else if (hp == TIMEOUT) begin
                        to = 1'b1;
                        mode = M_ACQ;
                        r_locked = 1'b0;
                        r_ratio = 0;
                        samples.delete();
                        restart = cyc + 1;
                    end
                end
            endcase
        end
        if (mvalid) begin
            check("range_err", 32'(range_err), 32'(er));
            check("timeout", 32'(timeout), 32'(to));
        end
        if (!rst_v) begin
            mode = M_IDLE;
            samples.delete();
            r_locked = 1'b0;
            r_ratio = 0;
            restart = cyc + 1;
            dly = '{1'b0, 1'b0, 1'b0};
            mvalid = 1'b1;
        end else begin
            dly[2] = dly[1];
            dly[1] = dly[0];
            dly[0] = din_lvl;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int d, input int n);
        div_d = d;
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1);
    endtask

    initial begin
        // reset with the input already toggling
        div_d = 1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        run(3, 40);                 // lock at D=3
        run(5, 60);                 // retune to D=5
        run(2, 40);                 // lock at D=2, then hold input for a timeout
        toggling = 1'b0;
        run(2, 230);
        toggling = 1'b1;
        run(11, 80);                // m=11 out of range
        run(7, 80);                 // top legal value
        run(0, 20);                 // toggle every cycle
        run(4, 50);                 // en abort while locked
        tick(1'b0, 1'b1);
        run(4, 50);
        run(6, 20);                 // reset mid-measurement
        tick(1'b1, 1'b0);
        run(6, 60);
        for (int s = 0; s < 25; s++) begin
            int d, n;
            d = $urandom_range(0, 12);
            n = $urandom_range(10, 120);
            if ($urandom_range(0, 5) == 0) toggling = 1'b0;
            run(d, n);
            toggling = 1'b1;
            if ($urandom_range(0, 4) == 0) tick(1'b0, 1'b1);
            if ($urandom_range(0, 9) == 0) tick(1'b1, 1'b0);
        end
        toggling = 1'b0;
        run(3, 210);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
